multi_alarm_controller: RTL and testbench

- Parametrised successor to the single-alarm keypad controller FSM. Sequences keypad digit entry and display selection for NUM_ALARMS alarm slots.
- Adds bounded digit counting, slot selection and an internal entry timeout.
- Sits between keypad scanner/one-second tick generator and the key shift register, alarm-slot registers, time counter and display mux.

---
 rtl/multi_alarm_controller.sv | 259 +++++++++++++++++++++++++
 tb/tb_multi_alarm_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_controller.sv
// multi_alarm_controller
// Keypad entry and display sequencer for NUM_ALARMS alarm slots. It counts the
// digits accepted for one entry, up to NUM_DIGITS. It selects the target alarm
// slot. It abandons an entry after TIMEOUT_SEC one_second ticks of inactivity.
// Every 1-bit output is registered from the next-state decode, so it lines up
// with the state register in the cycle after the sampling edge.
// Optional build macro: MULTI_ALARM_STRICT_ENTRY_EN. When it is defined, set
// commands that arrive before a full entry are rejected and entry_error pulses.
module multi_alarm_controller #(
    parameter int         NUM_ALARMS  = 4,
    parameter int         NUM_DIGITS  = 4,
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY       = 4'hF,
    localparam int        SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int        CNT_W       = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             one_second,
    input  logic             time_button,
    input  logic             alarm_button,
    input  logic             slot_button,
    input  logic [3:0]       key,
    output logic             reset_count,
    output logic             shift,
    output logic             show_new_time,
    output logic             show_a,
    output logic             load_new_a,
    output logic             load_new_c,
    output logic [SEL_W-1:0] alarm_sel,
    output logic [CNT_W-1:0] digit_count,
    output logic             entry_error
);

    localparam int TO_W = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;

    localparam logic [2:0] SHOW_TIME        = 3'd0;
    localparam logic [2:0] KEY_STORED       = 3'd1;
    localparam logic [2:0] KEY_WAITED       = 3'd2;
    localparam logic [2:0] KEY_ENTRY        = 3'd3;
    localparam logic [2:0] SHOW_ALARM       = 3'd4;
    localparam logic [2:0] SET_ALARM_TIME   = 3'd5;
    localparam logic [2:0] SET_CURRENT_TIME = 3'd6;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ALARMS - 1);

    // Output vector order: {reset_count, shift, show_new_time, show_a, load_new_a, load_new_c}
    function automatic logic [5:0] decode_outputs(input logic [2:0] st);
        logic [5:0] o;
        o = 6'b000000;
        case (st)
            KEY_STORED:            o = 6'b111000;
            KEY_WAITED, KEY_ENTRY: o = 6'b001000;
            SHOW_ALARM:            o = 6'b000100;
            SET_ALARM_TIME:        o = 6'b000010;
            SET_CURRENT_TIME:      o = 6'b000001;
            default:               o = 6'b000000;
        endcase
        return o;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [CNT_W-1:0] digit_count_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [SEL_W-1:0] alarm_sel_r;
    logic [SEL_W-1:0] sel_next_s;
    logic [SEL_W-1:0] sel_inc_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [TO_W-1:0]  to_next_s;
    logic [TO_W-1:0]  to_inc_s;
    logic             timeout_s;
    logic             key_s;
    logic             full_s;
    logic [5:0]       outs_r;
`ifdef MULTI_ALARM_STRICT_ENTRY_EN
    logic             err_next_s;
    logic             err_r;
`endif

    // Helper terms: key activity, full entry, wrapped slot increment, timeout tick.
    always_comb begin
        key_s  = (key != NOKEY);
        full_s = (digit_count_r >= CNT_FULL);
        if (alarm_sel_r >= SEL_LAST) begin
            sel_inc_s = {SEL_W{1'b0}};
        end else begin
            sel_inc_s = alarm_sel_r + SEL_W'(1);
        end
        // The counter holds at its last value so a late tick still expires the entry.
        if (one_second && (to_cnt_r != TO_LAST)) begin
            to_inc_s = to_cnt_r + TO_W'(1);
        end else begin
            to_inc_s = to_cnt_r;
        end
        timeout_s = one_second && (to_cnt_r == TO_LAST);
    end

    // Next-state, digit count, timeout counter and slot select decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = digit_count_r;
        sel_next_s   = alarm_sel_r;
        to_next_s    = {TO_W{1'b0}};
`ifdef MULTI_ALARM_STRICT_ENTRY_EN
        err_next_s   = 1'b0;
`endif
        case (state_r)
            SHOW_TIME: begin
                if (slot_button) begin
                    sel_next_s = sel_inc_s;
                end else begin
                    sel_next_s = alarm_sel_r;
                end
                if (alarm_button) begin
                    state_next_s = SHOW_ALARM;
                end else if (key_s) begin
                    state_next_s = KEY_STORED;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = SHOW_TIME;
                end
            end
            KEY_STORED: begin
                if (full_s) begin
                    cnt_next_s = digit_count_r;
                end else begin
                    cnt_next_s = digit_count_r + CNT_W'(1);
                end
                state_next_s = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!key_s) begin
                    state_next_s = KEY_ENTRY;
                    to_next_s    = to_inc_s;
                end else if (timeout_s) begin
                    state_next_s = SHOW_TIME;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = KEY_WAITED;
                    to_next_s    = to_inc_s;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
`ifdef MULTI_ALARM_STRICT_ENTRY_EN
                    if (!full_s) begin
                        state_next_s = SHOW_TIME;
                        cnt_next_s   = {CNT_W{1'b0}};
                        err_next_s   = 1'b1;
                    end else begin
                        state_next_s = SET_ALARM_TIME;
                    end
`else
                    state_next_s = SET_ALARM_TIME;
`endif
                end else if (time_button) begin
`ifdef MULTI_ALARM_STRICT_ENTRY_EN
                    if (!full_s) begin
                        state_next_s = SHOW_TIME;
                        cnt_next_s   = {CNT_W{1'b0}};
                        err_next_s   = 1'b1;
                    end else begin
                        state_next_s = SET_CURRENT_TIME;
                    end
`else
                    state_next_s = SET_CURRENT_TIME;
`endif
                end else if (key_s && !full_s) begin
                    state_next_s = KEY_STORED;
                end else if (timeout_s) begin
                    state_next_s = SHOW_TIME;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    // A key pressed at full count is dropped and does not restart the timeout.
                    state_next_s = KEY_ENTRY;
                    to_next_s    = to_inc_s;
                end
            end
            SHOW_ALARM: begin
                if (slot_button) begin
                    sel_next_s = sel_inc_s;
                end else begin
                    sel_next_s = alarm_sel_r;
                end
                if (alarm_button) begin
                    state_next_s = SHOW_ALARM;
                end else begin
                    state_next_s = SHOW_TIME;
                end
            end
            SET_ALARM_TIME: begin
                state_next_s = SHOW_TIME;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            SET_CURRENT_TIME: begin
                state_next_s = SHOW_TIME;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            default: begin
                // An unreachable encoding recovers to the idle display with a clean entry.
                state_next_s = SHOW_TIME;
                cnt_next_s   = {CNT_W{1'b0}};
                sel_next_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // State, digit count, timeout counter and slot select registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= SHOW_TIME;
            digit_count_r <= {CNT_W{1'b0}};
            alarm_sel_r   <= {SEL_W{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            digit_count_r <= cnt_next_s;
            alarm_sel_r   <= sel_next_s;
            to_cnt_r      <= to_next_s;
        end
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outs_r <= 6'b000000;
        end else begin
            outs_r <= decode_outputs(state_next_s);
        end
    end

    assign reset_count   = outs_r[5];
    assign shift         = outs_r[4];
    assign show_new_time = outs_r[3];
    assign show_a        = outs_r[2];
    assign load_new_a    = outs_r[1];
    assign load_new_c    = outs_r[0];
    assign alarm_sel     = alarm_sel_r;
    assign digit_count   = digit_count_r;

`ifdef MULTI_ALARM_STRICT_ENTRY_EN
    // One-cycle rejection flag, high in the SHOW_TIME entry cycle only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_next_s;
        end
    end

    assign entry_error = err_r;
`else
    assign entry_error = 1'b0;
`endif

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Self-checking bench for multi_alarm_controller (default parameters).
// The reference model works at the level of whole entries. It uses the slot count
// modulo NUM_ALARMS, the digits accepted as min(presses, NUM_DIGITS), and the expected
// pulse counts per command. A negedge monitor counts the output pulses.
module tb_multi_alarm_controller;

    localparam int         NA = 4;
    localparam int         ND = 4;
    localparam int         TS = 10;
    localparam logic [3:0] NK = 4'hF;
`ifdef MULTI_ALARM_STRICT_ENTRY_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       one_second;
    logic       time_button;
    logic       alarm_button;
    logic       slot_button;
    logic [3:0] key;
    logic       reset_count, shift, show_new_time, show_a, load_new_a, load_new_c, entry_error;
    logic [1:0] alarm_sel;
    logic [2:0] digit_count;

    int checks = 0;
    int errors = 0;
    int shift_seen = 0, load_a_seen = 0, load_c_seen = 0, err_seen = 0, last_sel = 0;

    multi_alarm_controller #(.NUM_ALARMS(NA), .NUM_DIGITS(ND), .TIMEOUT_SEC(TS), .NOKEY(NK)) dut (
        .clock(clock), .reset(reset), .one_second(one_second), .time_button(time_button),
        .alarm_button(alarm_button), .slot_button(slot_button), .key(key),
        .reset_count(reset_count), .shift(shift), .show_new_time(show_new_time), .show_a(show_a),
        .load_new_a(load_new_a), .load_new_c(load_new_c), .alarm_sel(alarm_sel),
        .digit_count(digit_count), .entry_error(entry_error)
    );

    always #5 clock = ~clock;

    // Pulse monitor: counts output cycles, sampled on the falling edge.
    always @(negedge clock) begin
        if (shift === 1'b1) shift_seen++;
        if (load_new_a === 1'b1) begin load_a_seen++; last_sel = int'(alarm_sel); end
        if (load_new_c === 1'b1) load_c_seen++;
        if (entry_error === 1'b1) err_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired before summary");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; key = NK; one_second = 1'b0; time_button = 1'b0;
        alarm_button = 1'b0; slot_button = 1'b0;
        #3; reset = 1'b0;
        tick(1);
    endtask

    task automatic press_key(input logic [3:0] k, input int hold, input int gap);
        key = k; tick(hold); key = NK; tick(gap);
    endtask

    task automatic slot_pulse();
        slot_button = 1'b1; tick(1); slot_button = 1'b0; tick(1);
    endtask

    task automatic command(input logic a, input logic t);
        alarm_button = a; time_button = t; tick(1);
        alarm_button = 1'b0; time_button = 1'b0; tick(3);
    endtask

    task automatic sec_tick();
        one_second = 1'b1; tick(1); one_second = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        reset = 1'b1; key = NK; one_second = 1'b0; time_button = 1'b0;
        alarm_button = 1'b0; slot_button = 1'b0;
        #20; reset = 1'b0; #2;
        outs = {reset_count, shift, show_new_time, show_a, load_new_a, load_new_c};
        checks++; if (outs !== 6'b0 || entry_error !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %b/%b want 000000/0", outs, entry_error); end
        checks++; if (alarm_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", alarm_sel); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", digit_count); end
        tick(1);
    endtask

    task automatic test_first_key();
        int s0;
        do_reset(); s0 = shift_seen;
        press_key(4'h1, 2, 2);
        checks++; if (shift_seen - s0 !== 1) begin errors++; $display("FAIL first_key_shift: got %0d want 1", shift_seen - s0); end
        checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL first_key_count: got %0d want 1", digit_count); end
        checks++; if (show_new_time !== 1'b1 || shift !== 1'b0) begin errors++; $display("FAIL first_key_entry: got snt=%b shift=%b want 1/0", show_new_time, shift); end
    endtask

    task automatic test_digit_limit();
        int s0;
        do_reset(); s0 = shift_seen;
        for (int i = 1; i <= 5; i++) press_key(4'(i), 2, 2);
        checks++; if (shift_seen - s0 !== 4) begin errors++; $display("FAIL limit_shifts: got %0d want 4", shift_seen - s0); end
        checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL limit_count: got %0d want 4", digit_count); end
    endtask

    task automatic test_slot_load();
        int la, lc;
        do_reset();
        for (int i = 0; i < 5; i++) slot_pulse();
        checks++; if (alarm_sel !== 2'd1) begin errors++; $display("FAIL slot_wrap: got %0d want 1", alarm_sel); end
        la = load_a_seen; lc = load_c_seen;
        for (int i = 0; i < 4; i++) press_key(4'(i + 6), 1, 2);
        command(1'b1, 1'b0);
        checks++; if (load_a_seen - la !== 1 || load_c_seen - lc !== 0) begin errors++; $display("FAIL slot_load_pulses: got a=%0d c=%0d want 1/0", load_a_seen - la, load_c_seen - lc); end
        checks++; if (last_sel !== 1) begin errors++; $display("FAIL slot_load_target: got %0d want 1", last_sel); end
        checks++; if (show_new_time !== 1'b0 || digit_count !== 3'd0) begin errors++; $display("FAIL slot_load_return: got snt=%b cnt=%0d want 0/0", show_new_time, digit_count); end
    endtask

    task automatic test_both_buttons();
        int la, lc;
        do_reset(); la = load_a_seen; lc = load_c_seen;
        for (int i = 0; i < 4; i++) press_key(4'(i), 2, 3);
        command(1'b1, 1'b1);
        checks++; if (load_a_seen - la !== 1 || load_c_seen - lc !== 0) begin errors++; $display("FAIL both_buttons: got a=%0d c=%0d want 1/0", load_a_seen - la, load_c_seen - lc); end
    endtask

    task automatic test_timeout();
        int la, lc;
        do_reset(); la = load_a_seen; lc = load_c_seen;
        press_key(4'h3, 2, 2);
        for (int i = 1; i <= TS; i++) begin
            sec_tick();
            checks++; if (show_new_time !== (i < TS)) begin errors++; $display("FAIL timeout_tick%0d: got snt=%b want %b", i, show_new_time, i < TS); end
        end
        checks++; if (digit_count !== 3'd0 || load_a_seen != la || load_c_seen != lc) begin errors++; $display("FAIL timeout_exit: got cnt=%0d loads=%0d want 0/0", digit_count, (load_a_seen - la) + (load_c_seen - lc)); end
        press_key(4'h4, 2, 2);
        for (int i = 0; i < TS - 1; i++) sec_tick();
        press_key(4'h5, 2, 2);
        for (int i = 0; i < TS - 1; i++) sec_tick();
        checks++; if (show_new_time !== 1'b1 || digit_count !== 3'd2) begin errors++; $display("FAIL timeout_restart: got snt=%b cnt=%0d want 1/2", show_new_time, digit_count); end
        sec_tick();
        checks++; if (show_new_time !== 1'b0 || digit_count !== 3'd0) begin errors++; $display("FAIL timeout_restart_exit: got snt=%b cnt=%0d want 0/0", show_new_time, digit_count); end
    endtask

    task automatic test_partial_entry();
        int lc, er, exp_lc, exp_er;
        do_reset(); lc = load_c_seen; er = err_seen;
        press_key(4'h7, 2, 2);
        press_key(4'h8, 2, 2);
        command(1'b0, 1'b1);
        exp_er = STRICT ? 1 : 0;
        exp_lc = STRICT ? 0 : 1;
        checks++; if (err_seen - er !== exp_er) begin errors++; $display("FAIL partial_error: got %0d want %0d", err_seen - er, exp_er); end
        checks++; if (load_c_seen - lc !== exp_lc) begin errors++; $display("FAIL partial_load_c: got %0d want %0d", load_c_seen - lc, exp_lc); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL partial_count: got %0d want 0", digit_count); end
    endtask

    task automatic test_reset_mid_entry();
        int la, lc;
        logic [5:0] outs;
        do_reset();
        slot_pulse(); slot_pulse();
        la = load_a_seen; lc = load_c_seen;
        key = 4'h9; tick(2);
        #2; reset = 1'b1; #1;
        outs = {reset_count, shift, show_new_time, show_a, load_new_a, load_new_c};
        checks++; if (outs !== 6'b0 || alarm_sel !== 2'd0 || digit_count !== 3'd0) begin errors++; $display("FAIL mid_reset: got outs=%b sel=%0d cnt=%0d want 0/0/0", outs, alarm_sel, digit_count); end
        #2; reset = 1'b0; key = NK; tick(3);
        checks++; if (show_new_time !== 1'b0 || load_a_seen != la || load_c_seen != lc) begin errors++; $display("FAIL mid_reset_after: got snt=%b loads=%0d want 0/0", show_new_time, (load_a_seen - la) + (load_c_seen - lc)); end
    endtask

    task automatic test_random();
        int msel, np, n, acc, cmd, s0, la, lc, er, exp_la, exp_lc, exp_er;
        bit hold, rej;
        do_reset(); msel = 0;
        for (int it = 0; it < 24; it++) begin
            np = $urandom_range(0, 5); hold = 1'($urandom_range(0, 1));
            if (hold) begin alarm_button = 1'b1; tick(1); end
            for (int i = 0; i < np; i++) slot_pulse();
            if (hold) begin
                checks++; if (show_a !== 1'b1) begin errors++; $display("FAIL rnd%0d_show_a: got %b want 1", it, show_a); end
                alarm_button = 1'b0; tick(2);
            end
            msel = (msel + np) % NA;
            checks++; if (int'(alarm_sel) !== msel) begin errors++; $display("FAIL rnd%0d_sel: got %0d want %0d", it, alarm_sel, msel); end
            n = $urandom_range(1, 6); s0 = shift_seen;
            for (int j = 0; j < n; j++) begin
                press_key(4'($urandom_range(0, 14)), $urandom_range(1, 3), $urandom_range(2, 3));
                if ($urandom_range(0, 3) == 0) slot_pulse();
            end
            acc = (n < ND) ? n : ND;
            checks++; if (shift_seen - s0 !== acc || int'(digit_count) !== acc) begin errors++; $display("FAIL rnd%0d_entry: got shifts=%0d cnt=%0d want %0d", it, shift_seen - s0, digit_count, acc); end
            cmd = $urandom_range(0, 3); la = load_a_seen; lc = load_c_seen; er = err_seen;
            case (cmd)
                0: command(1'b1, 1'b0);
                1: command(1'b0, 1'b1);
                2: command(1'b1, 1'b1);
                default: for (int i = 0; i < TS; i++) sec_tick();
            endcase
            rej = STRICT && (acc < ND) && (cmd != 3);
            exp_la = ((cmd == 0 || cmd == 2) && !rej) ? 1 : 0;
            exp_lc = (cmd == 1 && !rej) ? 1 : 0;
            exp_er = rej ? 1 : 0;
            checks++; if (load_a_seen - la !== exp_la || load_c_seen - lc !== exp_lc || err_seen - er !== exp_er) begin errors++; $display("FAIL rnd%0d_cmd%0d: got a=%0d c=%0d e=%0d want %0d/%0d/%0d", it, cmd, load_a_seen - la, load_c_seen - lc, err_seen - er, exp_la, exp_lc, exp_er); end
            if (exp_la == 1) begin
                checks++; if (last_sel !== msel) begin errors++; $display("FAIL rnd%0d_target: got %0d want %0d", it, last_sel, msel); end
            end
            checks++; if (show_new_time !== 1'b0 || digit_count !== 3'd0 || int'(alarm_sel) !== msel) begin errors++; $display("FAIL rnd%0d_idle: got snt=%b cnt=%0d sel=%0d want 0/0/%0d", it, show_new_time, digit_count, alarm_sel, msel); end
        end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_digit_limit();
        test_slot_load();
        test_both_buttons();
        test_timeout();
        test_partial_entry();
        test_reset_mid_entry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
